// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_rx
// Description : Framed serial receiver with parity check and framing-error
//               detection. A frame is: start bit (0), DATA_W data bits LSB
//               first, one parity bit, stop bit (1). One bit is consumed on
//               each cycle where bit_en is high. Good frames update data_out
//               with a one-cycle out_valid pulse; parity and framing errors
//               pulse their flags and bump a saturating 8-bit error counter.
//
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               bit_en     - bit strobe; serial_in sampled only when high
//               serial_in  - serial line, idles high
//               clr_count  - synchronous clear of err_count (wins over inc)
//               data_out   - last correctly framed word (held)
//               out_valid  - one-cycle pulse when data_out updates
//               parity_err - one-cycle pulse with out_valid on parity mismatch
//               frame_err  - one-cycle pulse when stop bit sampled as 0
//               err_count  - saturating count of parity/frame errors
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_rx #(
    parameter int DATA_W     = 3,
    parameter bit PARITY_ODD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              serial_in,
    input  logic              clr_count,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [7:0]        err_count
);

    localparam int c_CNT_W = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_DATA   = 2'd1;
    localparam logic [1:0] c_S_PARITY = 2'd2;
    localparam logic [1:0] c_S_STOP   = 2'd3;

    // Registered state
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par_bit;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_out_valid;
    logic               r_parity_err;
    logic               r_frame_err;
    logic [7:0]         r_err_count;

    // Next-state values
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic               w_par_bit_nxt;
    logic [DATA_W-1:0]  w_data_out_nxt;
    logic               w_out_valid_nxt;
    logic               w_parity_err_nxt;
    logic               w_frame_err_nxt;
    logic [7:0]         w_err_count_nxt;
    logic               w_exp_parity;

    assign w_exp_parity = PARITY_ODD ? ~(^r_shift) : (^r_shift);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_par_bit_nxt    = r_par_bit;
        w_data_out_nxt   = r_data_out;
        // Status flags are pulses: they drop unless re-raised this cycle.
        w_out_valid_nxt  = 1'b0;
        w_parity_err_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;

        if (bit_en) begin
            case (r_state)
                c_S_IDLE: begin
                    if (!serial_in) begin
                        w_state_nxt = c_S_DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                c_S_DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (r_cnt == c_CNT_W'(i)) begin
                            w_shift_nxt[i] = serial_in;
                        end
                    end
                    if (r_cnt == c_LAST_BIT) begin
                        w_state_nxt = c_S_PARITY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                c_S_PARITY: begin
                    w_par_bit_nxt = serial_in;
                    w_state_nxt   = c_S_STOP;
                end
                c_S_STOP: begin
                    w_state_nxt = c_S_IDLE;
                    if (serial_in) begin
                        w_data_out_nxt   = r_shift;
                        w_out_valid_nxt  = 1'b1;
                        w_parity_err_nxt = (r_par_bit != w_exp_parity);
                    end else begin
                        // Bad stop bit: word and parity result are discarded.
                        w_frame_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                end
            endcase
        end

        if (clr_count) begin
            w_err_count_nxt = 8'd0;
        end else if ((w_parity_err_nxt || w_frame_err_nxt) && (r_err_count != 8'hFF)) begin
            w_err_count_nxt = r_err_count + 8'd1;
        end else begin
            w_err_count_nxt = r_err_count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_data_out   <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_count  <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_par_bit    <= w_par_bit_nxt;
            r_data_out   <= w_data_out_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_err_count  <= w_err_count_nxt;
        end
    end

    assign data_out   = r_data_out;
    assign out_valid  = r_out_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_parity_rx
// Description : Self-checking bench for serial_parity_rx. Frames are built at
//               word level; a frame-level model predicts the output pulses,
//               held word and error count, compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_parity_rx;

    localparam int c_DATA_W     = 3;
    localparam bit c_PARITY_ODD = 1'b1;

    logic                clk;
    logic                rst_n;
    logic                bit_en;
    logic                serial_in;
    logic                clr_count;
    logic [c_DATA_W-1:0] data_out;
    logic                out_valid;
    logic                parity_err;
    logic                frame_err;
    logic [7:0]          err_count;

    serial_parity_rx #(
        .DATA_W    (c_DATA_W),
        .PARITY_ODD(c_PARITY_ODD)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .serial_in (serial_in),
        .clr_count (clr_count),
        .data_out  (data_out),
        .out_valid (out_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic exp_par(input logic [c_DATA_W-1:0] d);
        return c_PARITY_ODD ? ~(^d) : (^d);
    endfunction

    // ---------------- frame-level model ----------------
    // The driver posts the outcome of a frame while presenting its stop bit;
    // the model applies it at the edge that samples that bit.
    logic                pend;
    logic                p_stop_ok;
    logic                p_perr;
    logic [c_DATA_W-1:0] p_data;

    logic                m_valid, m_perr, m_ferr;
    logic [c_DATA_W-1:0] m_data;
    int                  m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
            m_data  = '0;   m_cnt  = 0;    pend   = 1'b0;
        end else begin
            m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
            if (pend) begin
                if (p_stop_ok) begin
                    m_valid = 1'b1;
                    m_data  = p_data;
                    m_perr  = p_perr;
                end else begin
                    m_ferr = 1'b1;
                end
                pend = 1'b0;
            end
            if (clr_count)                     m_cnt = 0;
            else if ((m_perr || m_ferr) && m_cnt < 255) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("out_valid",  {15'd0, out_valid},  {15'd0, m_valid});
        chk("parity_err", {15'd0, parity_err}, {15'd0, m_perr});
        chk("frame_err",  {15'd0, frame_err},  {15'd0, m_ferr});
        chk("data_out",   16'(data_out),       16'(m_data));
        chk("err_count",  16'(err_count),      16'(m_cnt));
    end

    // ---------------- drivers ----------------
    task automatic send_bit(input logic b, input int gap);
        serial_in = b;
        bit_en    = 1'b1;
        @(posedge clk); #1;
        bit_en    = 1'b0;
        serial_in = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Returns one time unit after the edge that samples the stop bit.
    task automatic send_frame(input logic [c_DATA_W-1:0] d, input logic par,
                              input logic stop, input int gap, input logic clr);
        send_bit(1'b0, gap);
        for (int i = 0; i < c_DATA_W; i++) send_bit(d[i], gap);
        send_bit(par, gap);
        p_data    = d;
        p_stop_ok = stop;
        p_perr    = (par != exp_par(d));
        pend      = 1'b1;
        clr_count = clr;
        send_bit(stop, 0);
        clr_count = 1'b0;
    endtask

    initial begin
        logic [c_DATA_W-1:0] w;
        logic                pb;
        pend = 1'b0; p_stop_ok = 1'b0; p_perr = 1'b0; p_data = '0;
        rst_n = 1'b0; bit_en = 1'b0; serial_in = 1'b1; clr_count = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_out",  16'(data_out),  16'h0);
        chk("reset err_count", 16'(err_count), 16'h0);
        chk("reset out_valid", {15'd0, out_valid}, 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good frame 101, parity 1
        send_frame(3'b101, 1'b1, 1'b1, 0, 1'b0);
        chk("t1 data",  16'(data_out), 16'h5);
        chk("t1 valid", {15'd0, out_valid}, 16'h1);
        chk("t1 perr",  {15'd0, parity_err}, 16'h0);
        chk("t1 cnt",   16'(err_count), 16'h0);
        @(posedge clk); #1;
        chk("t1 pulse width", {15'd0, out_valid}, 16'h0);

        // Same word, bad parity
        send_frame(3'b101, 1'b0, 1'b1, 0, 1'b0);
        chk("t2 valid", {15'd0, out_valid}, 16'h1);
        chk("t2 perr",  {15'd0, parity_err}, 16'h1);
        chk("t2 cnt",   16'(err_count), 16'h1);

        // Frame error, back-to-back with previous frame
        send_frame(3'b110, 1'b1, 1'b0, 0, 1'b0);
        chk("t3 ferr",  {15'd0, frame_err}, 16'h1);
        chk("t3 valid", {15'd0, out_valid}, 16'h0);
        chk("t3 data held", 16'(data_out), 16'h5);
        chk("t3 cnt",   16'(err_count), 16'h2);

        // Idle line then gapped frame
        repeat (10) send_bit(1'b1, 0);
        send_frame(3'b011, 1'b1, 1'b1, 3, 1'b0);
        chk("t4 data",  16'(data_out), 16'h3);
        chk("t4 valid", {15'd0, out_valid}, 16'h1);

        // Reset mid-frame
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        rst_n = 1'b0;
        #1;
        chk("t5 rst data", 16'(data_out), 16'h0);
        chk("t5 rst cnt",  16'(err_count), 16'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(3'b111, 1'b0, 1'b1, 0, 1'b0);
        chk("t5 data",  16'(data_out), 16'h7);
        chk("t5 perr",  {15'd0, parity_err}, 16'h0);
        chk("t5 valid", {15'd0, out_valid}, 16'h1);

        // Randomized mix of good, bad-parity and bad-stop frames
        for (int k = 0; k < 40; k++) begin
            w  = c_DATA_W'($urandom);
            pb = exp_par(w) ^ ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) send_bit(1'b1, $urandom_range(0, 1));
            send_frame(w, pb, ($urandom_range(0, 3) != 0), $urandom_range(0, 2),
                       ($urandom_range(0, 9) == 0));
        end

        // Saturation
        for (int k = 0; k < 260; k++) send_frame(c_DATA_W'(k), ~exp_par(c_DATA_W'(k)), 1'b1, 0, 1'b0);
        chk("sat cnt", 16'(err_count), 16'd255);
        send_frame(3'b010, 1'b1, 1'b1, 0, 1'b1);
        chk("clr perr", {15'd0, parity_err}, 16'h1);
        chk("clr cnt",  16'(err_count), 16'h0);

        // Random good words
        for (int k = 0; k < 25; k++) begin
            w = c_DATA_W'($urandom);
            send_frame(w, ~(^w), 1'b1, $urandom_range(0, 2), 1'b0);
            chk("rand data", 16'(data_out), 16'(w));
        end
        chk("final cnt", 16'(err_count), 16'h0);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
Receiving end of the odd-parity (XNOR) link. The existing generator computes parity as ~(A^B^C) for a 3-bit word. This block deserializes framed words from a 1-bit serial line, checks parity, and flags framing errors. It presents each received word with a one-cycle valid pulse and keeps a saturating error counter for the status logic.

Parameters:
DATA_W, 3, number of data bits per frame (range 1..16).
PARITY_ODD, 1, 1 = odd parity (expected parity = ~^data); 0 = even parity (expected parity = ^data).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
bit_en  input  1  bit strobe; serial_in is sampled only on cycles where bit_en=1.
serial_in  input  1  serial line; idles high.
clr_count  input  1  synchronous clear of err_count.
data_out  output  DATA_W  last correctly framed word; held until the next good frame.
out_valid  output  1  one-cycle pulse when data_out updates.
parity_err  output  1  one-cycle pulse, coincident with out_valid, when the parity bit mismatches.
frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
err_count  output  8  saturating count of parity_err plus frame_err events.

Behaviour:
- Frame format, in order: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1). Exactly one bit is consumed per bit_en cycle.
- Reset (rst_n=0, asynchronous): state=IDLE; bit counter, shift register, data_out, out_valid, parity_err, frame_err and err_count all go to 0. No output activity occurs until a new start bit is seen.
- When bit_en=0, the FSM, counter and shift register hold.
- FSM states:
  - IDLE: on bit_en with serial_in=0 -> DATA, counter=0. With serial_in=1 -> stay in IDLE.
  - DATA: on bit_en, shift_reg[counter]<=serial_in and counter increments. After the DATA_W-th bit -> PARITY.
  - PARITY: on bit_en, capture the parity bit -> STOP.
  - STOP: on bit_en -> IDLE unconditionally.
    - If serial_in=1: data_out<=shift_reg and out_valid<=1. Also parity_err<=(captured parity != expected parity of shift_reg).
    - If serial_in=0: frame_err<=1. out_valid stays 0, data_out is unchanged and the parity result is discarded.
- Latency: out_valid, parity_err and frame_err are registered and become high in the cycle after the clock edge that samples the stop bit. Each is high for exactly one cycle.
- Back-to-back frames: the next start bit may arrive on the very next bit_en after the stop bit.
- err_count:
  - Increments by 1 in the same edge that raises parity_err or frame_err.
  - Holds at 255; it never wraps.
  - clr_count=1 forces 0 and takes priority over a simultaneous increment.
- Reset mid-frame aborts the frame: no partial word is emitted and no error is counted.
- The counter width is clog2(DATA_W+1). There are no illegal-state hangs: any unused encoding returns to IDLE.

Test Plan:
- Default parameters, word 3'b101 (XOR=0 -> parity bit 1). Frame 0,1,0,1,1,1 on consecutive bit_en cycles -> data_out=3'b101, out_valid high for one cycle, parity_err=0, err_count=0.
- Same frame with parity bit 0 -> out_valid=1 and parity_err=1 in the same cycle, data_out=3'b101, err_count=1.
- Word 3'b110 with stop bit 0 -> frame_err for one cycle, out_valid stays 0, data_out keeps its previous value, err_count increments by 1.
- Line held at 1 for 10 bit_en cycles, then frame 3'b011 (parity 1) with bit_en=0 gaps of 3 cycles between bits -> no output during idle, then data_out=3'b011 with one out_valid pulse.
- rst_n pulsed low after 2 data bits -> all outputs read 0 immediately. A following full frame 3'b111 (XOR=1 -> parity 0) is received with parity_err=0.
- 260 frames with bad parity -> err_count stops at 255. clr_count asserted in the same cycle as an error pulse -> err_count=0. Then 25 random words sent with a model parity of ~^data -> every word matches and no errors are counted.
